// File: rtl/mig_rdata_buf.sv
// Credit-based read-data buffer between a MIG read port and a ready/valid consumer.
// Optional same-cycle bypass when empty: define MIG_RDATA_BYPASS_EN.
module mig_rdata_buf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = 4
) (
    input  logic            mclk,
    input  logic            mrst,
    input  logic            rd_req_valid,
    input  logic [ID_W-1:0] rd_req_id,
    output logic            rd_req_ready,
    input  logic [127:0]    app_rd_data,
    input  logic            app_rd_data_valid,
    input  logic            app_rd_data_end,
    output logic [127:0]    rdata,
    output logic [ID_W-1:0] rid,
    output logic            rvalid,
    input  logic            rready,
    output logic            rd_err
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned EntW = 128 + ID_W;

    logic [ID_W-1:0] idq_mem [DEPTH];
    logic [PtrW-1:0] idq_wptr_q, idq_rptr_q;
    logic [CntW-1:0] idq_cnt_q, idq_cnt_d;

    logic [EntW-1:0] fifo_mem [DEPTH];
    logic [PtrW-1:0] fifo_wptr_q, fifo_rptr_q;
    logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [CntW-1:0] cnt;
    logic            rd_err_q, rd_err_d;
    logic            fire, matched, bypass, fifo_push, fifo_pop, fifo_nonempty;
    logic [ID_W-1:0] head_id;
    logic [EntW-1:0] head_ent;

    // Credits cover both in-flight reads and stored beats, so the FIFO can never overflow.
    assign cnt           = idq_cnt_q + fifo_cnt_q;
    assign rd_req_ready  = ~mrst & (cnt < CntW'(DEPTH));
    assign fire          = rd_req_valid & rd_req_ready;
    // Registered reserved count: a credit granted this cycle cannot match a beat this cycle.
    assign matched       = app_rd_data_valid & (idq_cnt_q != '0) & ~mrst;
    assign head_id       = idq_mem[idq_rptr_q];
    assign head_ent      = fifo_mem[fifo_rptr_q];
    assign fifo_nonempty = (fifo_cnt_q != '0);

`ifdef MIG_RDATA_BYPASS_EN
    assign bypass = matched & ~fifo_nonempty & rready;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = matched & ~bypass;
    assign fifo_pop  = fifo_nonempty & rready & ~mrst;
    assign rd_err    = rd_err_q;

    always_comb begin
        idq_cnt_d = idq_cnt_q;
        if (fire)    idq_cnt_d = idq_cnt_d + CntW'(1);
        if (matched) idq_cnt_d = idq_cnt_d - CntW'(1);
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_push) fifo_cnt_d = fifo_cnt_d + CntW'(1);
        if (fifo_pop)  fifo_cnt_d = fifo_cnt_d - CntW'(1);
    end

    always_comb begin
        rd_err_d = rd_err_q;
        if (app_rd_data_valid && !mrst && (!matched || !app_rd_data_end)) rd_err_d = 1'b1;
    end

    always_comb begin
        rvalid = 1'b0;
        rdata  = '0;
        rid    = '0;
        if (!mrst) begin
            if (fifo_nonempty) begin
                rvalid = 1'b1;
                rdata  = head_ent[EntW-1:ID_W];
                rid    = head_ent[ID_W-1:0];
            end
`ifdef MIG_RDATA_BYPASS_EN
            else if (bypass) begin
                rvalid = 1'b1;
                rdata  = app_rd_data;
                rid    = head_id;
            end
`endif
        end
    end

    always_ff @(posedge mclk) begin
        if (mrst) begin
            idq_wptr_q  <= '0;
            idq_rptr_q  <= '0;
            idq_cnt_q   <= '0;
            fifo_wptr_q <= '0;
            fifo_rptr_q <= '0;
            fifo_cnt_q  <= '0;
            rd_err_q    <= 1'b0;
        end else begin
            if (fire)      idq_wptr_q  <= idq_wptr_q + PtrW'(1);
            if (matched)   idq_rptr_q  <= idq_rptr_q + PtrW'(1);
            if (fifo_push) fifo_wptr_q <= fifo_wptr_q + PtrW'(1);
            if (fifo_pop)  fifo_rptr_q <= fifo_rptr_q + PtrW'(1);
            idq_cnt_q  <= idq_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            rd_err_q   <= rd_err_d;
        end
    end

    // Storage arrays need no reset; occupancy counts define validity.
    always_ff @(posedge mclk) begin
        if (fire)      idq_mem[idq_wptr_q]   <= rd_req_id;
        if (fifo_push) fifo_mem[fifo_wptr_q] <= {app_rd_data, head_id};
    end

endmodule
